ahb_slave_mem: RTL

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_slave_ram.sv | 24 ++
 rtl/ahb_slave_mem.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the slave FSM state type used by the memory slave and its bench.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored by slaves.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Word-wide storage for the AHB memory slave: one synchronous write port, one asynchronous read port.
module ahb_slave_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave with programmable data-phase wait states and a two-cycle ERROR response
// for unaligned, non-word or out-of-range transfers.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DEPTH       = 16
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic            active_q, active_d;
  logic            capture;
  logic            addr_err;
  logic            mem_we;
  logic [31:0]     mem_rdata;

  assign capture  = hsel && hready && is_active(htrans);
  assign addr_err = (hsize != HSIZE_WORD) || (haddr[1:0] != 2'b00) ||
                    ({2'b00, haddr[31:2]} >= 32'(DEPTH));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    active_d  = active_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;

    case (state_q)
      ST_WAIT: begin
        hreadyout = 1'b0;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp = HRESP_ERROR;
      end
      default: begin
      end
    endcase

    // IDLE and ERR2 are the ready cycles in which the next address phase may be accepted.
    if ((state_q == ST_IDLE) || (state_q == ST_ERR2)) begin
      state_d  = ST_IDLE;
      active_d = 1'b0;
      if (capture) begin
        addr_d  = haddr[AW+1:2];
        write_d = hwrite;
        if (addr_err) begin
          state_d = ST_ERR1;
        end else begin
          active_d = 1'b1;
          if (WS != 3'd0) begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
    end
  end

  assign mem_we = (state_q == ST_IDLE) && active_q && write_q;
  assign hrdata = ((state_q == ST_IDLE) && active_q && !write_q) ? mem_rdata : 32'h0;

  ahb_slave_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (hclk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (hwdata),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

endmodule
